// File: rtl/hdmi_word_align_pkg.sv
// Shared constants for TMDS word alignment: control tokens, FSM states, shift range.
package hdmi_align_pkg;

   localparam int          SHIFT_W   = 4;
   localparam logic [3:0]  SHIFT_MAX = 4'd9;

   localparam logic [9:0]  TOK_C00   = 10'h354;
   localparam logic [9:0]  TOK_C01   = 10'h0AB;
   localparam logic [9:0]  TOK_C10   = 10'h154;
   localparam logic [9:0]  TOK_C11   = 10'h2AB;

   localparam logic [1:0]  CODE_C00  = 2'b00;
   localparam logic [1:0]  CODE_C01  = 2'b01;
   localparam logic [1:0]  CODE_C10  = 2'b10;
   localparam logic [1:0]  CODE_C11  = 2'b11;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } align_state_t;

   function automatic logic [3:0] next_shift(input logic [3:0] shift);
      if (shift >= SHIFT_MAX) begin
         return 4'd0;
      end else begin
         return shift + 4'd1;
      end
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      if (value == 8'hFF) begin
         return 8'hFF;
      end else begin
         return value + 8'd1;
      end
   endfunction

endpackage

// File: rtl/hdmi_ctrl_detect.sv
// Combinational TMDS control-token detector: 10-bit symbol -> {is_ctrl, {C1,C0}}.
module hdmi_ctrl_detect
   import hdmi_align_pkg::*;
(
   input  logic [9:0] word,
   output logic       is_ctrl,
   output logic [1:0] code
);

   // Match the four control tokens; everything else is data.
   always_comb begin
      is_ctrl = 1'b0;
      code    = 2'b00;
      case (word)
         TOK_C00: begin is_ctrl = 1'b1; code = CODE_C00; end
         TOK_C01: begin is_ctrl = 1'b1; code = CODE_C01; end
         TOK_C10: begin is_ctrl = 1'b1; code = CODE_C10; end
         TOK_C11: begin is_ctrl = 1'b1; code = CODE_C11; end
         default: begin is_ctrl = 1'b0; code = 2'b00;    end
      endcase
   end

endmodule

// File: rtl/hdmi_word_align.sv
// TMDS word aligner: searches bit rotations for control-token runs, locks, and re-searches on loss.
// Optional statistics (o_slips, o_losses) are built when HDMI_WORD_ALIGN_STATS_EN is defined.
module hdmi_word_align
   import hdmi_align_pkg::*;
#(
   parameter int LOCK_COUNT    = 8,
   parameter int SEARCH_WINDOW = 4096,
   parameter int MISS_LIMIT    = 2097152
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [9:0]          i_word,
   output logic [9:0]          o_word,
   output logic                o_locked,
   output logic [SHIFT_W-1:0]  o_shift,
   output logic                o_ctrl,
   output logic [1:0]          o_ctrl_code
`ifdef HDMI_WORD_ALIGN_STATS_EN
   ,
   output logic [7:0]          o_slips,
   output logic [7:0]          o_losses
`endif
);

   localparam logic [7:0]  RUN_LOCK  = 8'(LOCK_COUNT);
   localparam logic [15:0] WIN_LAST  = 16'(SEARCH_WINDOW - 1);
   localparam logic [23:0] MISS_LAST = 24'(MISS_LIMIT - 1);

   align_state_t       state_r;
   logic [9:0]         prev_r;
   logic [SHIFT_W-1:0] shift_r;
   logic [7:0]         run_cnt_r;
   logic [15:0]        win_cnt_r;
   logic [23:0]        miss_cnt_r;
   logic [9:0]         word_r;
   logic               locked_r;
   logic               ctrl_r;
   logic [1:0]         code_r;
   logic [9:0]         cand_s;
   logic               cand_ctrl_s;
   logic [1:0]         cand_code_s;
   logic               out_ctrl_s;
   logic [1:0]         out_code_s;
`ifdef HDMI_WORD_ALIGN_STATS_EN
   logic [7:0]         slips_r;
   logic [7:0]         losses_r;
`endif

   // Candidate symbol: 10 bits of {i_word, prev_r} starting at the current shift.
   always_comb begin
      cand_s = prev_r;
      case (shift_r)
         4'd0:    cand_s = prev_r;
         4'd1:    cand_s = {i_word[0],   prev_r[9:1]};
         4'd2:    cand_s = {i_word[1:0], prev_r[9:2]};
         4'd3:    cand_s = {i_word[2:0], prev_r[9:3]};
         4'd4:    cand_s = {i_word[3:0], prev_r[9:4]};
         4'd5:    cand_s = {i_word[4:0], prev_r[9:5]};
         4'd6:    cand_s = {i_word[5:0], prev_r[9:6]};
         4'd7:    cand_s = {i_word[6:0], prev_r[9:7]};
         4'd8:    cand_s = {i_word[7:0], prev_r[9:8]};
         4'd9:    cand_s = {i_word[8:0], prev_r[9]};
         default: cand_s = prev_r;
      endcase
   end

   hdmi_ctrl_detect u_run_detect (
      .word    (cand_s),
      .is_ctrl (cand_ctrl_s),
      .code    (cand_code_s)
   );

   hdmi_ctrl_detect u_out_detect (
      .word    (cand_s),
      .is_ctrl (out_ctrl_s),
      .code    (out_code_s)
   );

   // Datapath registers, run/window/miss counters and the SEARCH/LOCKED FSM.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r    <= SEARCH;
         prev_r     <= 10'd0;
         shift_r    <= 4'd0;
         run_cnt_r  <= 8'd0;
         win_cnt_r  <= 16'd0;
         miss_cnt_r <= 24'd0;
         word_r     <= 10'd0;
         locked_r   <= 1'b0;
         ctrl_r     <= 1'b0;
         code_r     <= 2'b00;
`ifdef HDMI_WORD_ALIGN_STATS_EN
         slips_r    <= 8'd0;
         losses_r   <= 8'd0;
`endif
      end else begin
         prev_r    <= i_word;
         word_r    <= cand_s;
         ctrl_r    <= out_ctrl_s;
         code_r    <= out_code_s;
         run_cnt_r <= cand_ctrl_s ? sat_inc8(run_cnt_r) : 8'd0;
         case (state_r)
            SEARCH: begin
               // A completed run takes priority over the window rolling over.
               if (run_cnt_r >= RUN_LOCK) begin
                  state_r    <= LOCKED;
                  locked_r   <= 1'b1;
                  miss_cnt_r <= 24'd0;
                  win_cnt_r  <= 16'd0;
               end else if (win_cnt_r == WIN_LAST) begin
                  shift_r    <= next_shift(shift_r);
                  run_cnt_r  <= 8'd0;
                  win_cnt_r  <= 16'd0;
`ifdef HDMI_WORD_ALIGN_STATS_EN
                  slips_r    <= sat_inc8(slips_r);
`endif
               end else begin
                  win_cnt_r  <= win_cnt_r + 16'd1;
               end
            end
            LOCKED: begin
               if (run_cnt_r >= RUN_LOCK) begin
                  miss_cnt_r <= 24'd0;
               end else if (miss_cnt_r == MISS_LAST) begin
                  state_r    <= SEARCH;
                  locked_r   <= 1'b0;
                  shift_r    <= next_shift(shift_r);
                  run_cnt_r  <= 8'd0;
                  win_cnt_r  <= 16'd0;
                  miss_cnt_r <= 24'd0;
`ifdef HDMI_WORD_ALIGN_STATS_EN
                  slips_r    <= sat_inc8(slips_r);
                  losses_r   <= sat_inc8(losses_r);
`endif
               end else begin
                  miss_cnt_r <= miss_cnt_r + 24'd1;
               end
            end
            default: begin
               state_r  <= SEARCH;
               locked_r <= 1'b0;
            end
         endcase
      end
   end

   assign o_word      = word_r;
   assign o_locked    = locked_r;
   assign o_shift     = shift_r;
   assign o_ctrl      = ctrl_r;
   assign o_ctrl_code = code_r;
`ifdef HDMI_WORD_ALIGN_STATS_EN
   assign o_slips     = slips_r;
   assign o_losses    = losses_r;
`endif

endmodule

// File: doc/hdmi_word_align.md
Name: hdmi_word_align

Overview:
- Sits directly downstream of the per-lane 10:1 HDMI input deserializer, in the same pixel-clock domain.
- Takes the raw, arbitrarily bit-rotated 10-bit TMDS words it produces and finds the bit rotation where the TMDS control tokens line up.
- Outputs word-aligned 10-bit symbols, a lock flag and the selected shift to the TMDS decoder.
- Tracks loss of alignment and restarts the search on its own.

Parameters:
- LOCK_COUNT, 8: consecutive control tokens at one shift required to declare lock (legal range 2..255).
- SEARCH_WINDOW, 4096: cycles spent testing each candidate shift before advancing (power of two, at most 2^16).
- MISS_LIMIT, 2^21: cycles in LOCKED without a qualifying control run before lock is dropped (at most 2^24).

Ports:
- i_clk  input  1  pixel clock, same clock as the deserializer's word clock
- i_reset  input  1  synchronous, active-high reset
- i_word  input  10  raw deserialized word, valid every cycle
- o_word  output  10  aligned TMDS symbol
- o_locked  output  1  alignment lock indicator
- o_shift  output  4  current bit rotation, 0..9
- o_ctrl  output  1  o_word is one of the four control tokens
- o_ctrl_code  output  2  decoded {C1,C0} when o_ctrl is 1, otherwise 0

Behaviour:
Interface decision:
- One clock; reset is synchronous and active-high (i_clk, i_reset).

Datapath:
- r_prev <= i_word every cycle.
- Window is {i_word, r_prev}, 20 bits.
- Candidate word = window[shift+9 : shift]. Shift 0 selects r_prev exactly.
- o_word, o_ctrl and o_ctrl_code are registered from the candidate word: 1 cycle latency from i_word.
- Control tokens: 10'h354 -> 00, 10'h0AB -> 01, 10'h154 -> 10, 10'h2AB -> 11.

Counters:
- run_cnt: 8 bits, saturating. Increments on each candidate control token; clears on any non-token.
- win_cnt: cycle counter within the current search window.
- miss_cnt: 24 bits, used in LOCKED.

State machine (SEARCH, LOCKED):
- SEARCH:
  - Each cycle, win_cnt increments.
  - If run_cnt reaches LOCK_COUNT: go to LOCKED, clear miss_cnt, keep shift.
  - Else, when win_cnt reaches SEARCH_WINDOW-1: shift <= (shift==9) ? 0 : shift+1, and clear run_cnt and win_cnt on the same cycle.
  - If lock and window end occur in the same cycle, lock wins; shift is unchanged.
- LOCKED:
  - shift is frozen.
  - miss_cnt increments each cycle.
  - run_cnt reaching LOCK_COUNT clears miss_cnt.
  - miss_cnt reaching MISS_LIMIT-1: go to SEARCH and advance shift (9 wraps to 0), clearing run_cnt, win_cnt and miss_cnt.
  - A run continuing past LOCK_COUNT keeps miss_cnt at 0; run_cnt saturates at 255.

Outputs:
- o_locked is 1 exactly while in LOCKED, updating on the cycle after the transition.
- o_word is passed through in both states; the decoder must gate on o_locked.
- o_shift is the registered shift.

Reset (synchronous, takes effect in any state including mid-search or mid-lock):
- State = SEARCH; shift, all counters and r_prev = 0.
- o_word=0, o_locked=0, o_shift=0, o_ctrl=0, o_ctrl_code=0.

Optional Feature:
HDMI_WORD_ALIGN_STATS_EN
- Defined: adds output o_slips[7:0] (reset 0).
  - Increments, saturating at 255, on every shift advance in either state.
  - Adds output o_losses[7:0] (reset 0), incrementing, saturating, on every LOCKED->SEARCH transition.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package hdmi_align_pkg:
  - Four control-token constants and their 2-bit codes.
  - State enum {SEARCH, LOCKED}.
  - Shift width (4) and maximum shift (9).
- Sub-module hdmi_ctrl_detect: purely combinational 10-bit -> {is_ctrl, code[1:0]}. It is instantiated twice: once on the candidate word for run_cnt, once for the registered o_ctrl outputs, so the TMDS decoder can reuse it.

Test Plan:
- Aligned stream, shift 0, of 10'h354 repeated 20 times, SEARCH_WINDOW=64, LOCK_COUNT=8 -> o_locked rises at most 10 cycles after the first token; o_shift=0; o_ctrl_code=00.
- Stream rotated by 3 bits, with 0x0AB blanking runs of 16 every 200 cycles, SEARCH_WINDOW=64 -> o_shift steps 0,1,2,3 at 64-cycle intervals; lock at shift 3; o_word=10'h0AB with o_ctrl_code=01.
- Locked, then control tokens removed, MISS_LIMIT=1000 -> o_locked falls 1000 cycles after the last qualifying run; o_shift advances by 1.
- Random data containing no 8-token runs for 700 cycles, SEARCH_WINDOW=64 -> o_shift wraps 9->0 and o_locked stays 0.
- Run of 8 tokens completing on the final window cycle -> LOCKED entered with shift unchanged.
- i_reset asserted for 1 cycle while LOCKED at shift 5 -> next cycle o_locked=0, o_shift=0, o_word=0 (and with HDMI_WORD_ALIGN_STATS_EN, o_slips=0, o_losses=0).
